// File: rtl/conv_layer_sched_pkg.sv
// Shared widths and FSM state type for the convolution layer scheduler.
package conv_layer_sched_pkg;
    localparam int DEF_TENSOR_SIZE      = 8;
    localparam int DEF_KERNEL_SIZE      = 4;
    localparam int DEF_CHANNELS_SIZE    = 8;
    localparam int DEF_STRIDE_SIZE      = 2;
    localparam int DEF_KERNEL_NUMS_SIZE = 8;
    localparam int DEF_FIFO_DEPTH       = 4;
    localparam int DEF_GAP_CYCLES       = 2;
    localparam int DEF_WDOG_W           = 24;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_GAP, S_ERR
    } sched_state_e;
endpackage

// File: rtl/conv_layer_sched_if.sv
// Descriptor intake and core configuration bus; master is the scheduler side.
interface conv_layer_sched_if #(
    parameter int TENSOR_SIZE      = conv_layer_sched_pkg::DEF_TENSOR_SIZE,
    parameter int KERNEL_SIZE      = conv_layer_sched_pkg::DEF_KERNEL_SIZE,
    parameter int CHANNELS_SIZE    = conv_layer_sched_pkg::DEF_CHANNELS_SIZE,
    parameter int STRIDE_SIZE      = conv_layer_sched_pkg::DEF_STRIDE_SIZE,
    parameter int KERNEL_NUMS_SIZE = conv_layer_sched_pkg::DEF_KERNEL_NUMS_SIZE
) ();
    logic                        desc_valid;
    logic                        desc_ready;
    logic [TENSOR_SIZE-1:0]      desc_tensor_size, cfg_tensor_size;
    logic [KERNEL_SIZE-1:0]      desc_kernel_size, cfg_kernel_size;
    logic [CHANNELS_SIZE-1:0]    desc_channels,    cfg_channels;
    logic [STRIDE_SIZE-1:0]      desc_stride,      cfg_stride;
    logic [KERNEL_NUMS_SIZE-1:0] desc_kernel_nums, cfg_kernel_nums;
    logic                        acc_start;
    logic                        acc_w_done;

    modport master (
        input  desc_valid, desc_tensor_size, desc_kernel_size, desc_channels,
               desc_stride, desc_kernel_nums, acc_w_done,
        output desc_ready, cfg_tensor_size, cfg_kernel_size, cfg_channels,
               cfg_stride, cfg_kernel_nums, acc_start
    );
    modport slave (
        output desc_valid, desc_tensor_size, desc_kernel_size, desc_channels,
               desc_stride, desc_kernel_nums, acc_w_done,
        input  desc_ready, cfg_tensor_size, cfg_kernel_size, cfg_channels,
               cfg_stride, cfg_kernel_nums, acc_start
    );
endinterface

// File: rtl/conv_layer_sched_fifo.sv
// Synchronous descriptor queue with occupancy count and a flush that empties it.
module layer_desc_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    lvl_q;
    logic             do_push, do_pop;

    assign full_o  = (lvl_q == LW'(DEPTH));
    assign empty_o = (lvl_q == '0);
    assign level_o = lvl_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset; the level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: queues descriptors, launches one core run per layer, retires on w_done rise.
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int TENSOR_SIZE      = DEF_TENSOR_SIZE,
    parameter int KERNEL_SIZE      = DEF_KERNEL_SIZE,
    parameter int CHANNELS_SIZE    = DEF_CHANNELS_SIZE,
    parameter int STRIDE_SIZE      = DEF_STRIDE_SIZE,
    parameter int KERNEL_NUMS_SIZE = DEF_KERNEL_NUMS_SIZE,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES       = DEF_GAP_CYCLES,
    parameter int WDOG_W           = DEF_WDOG_W,
    localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic               err_clr,
    conv_layer_sched_if.master bus,
    output logic               res_bank,
    output logic               busy,
    output logic               layer_done,
    output logic [7:0]         layers_done,
    output logic [LVL_W-1:0]   fifo_level,
    output logic               err
);
    localparam int DESC_W = TENSOR_SIZE + KERNEL_SIZE + CHANNELS_SIZE + STRIDE_SIZE + KERNEL_NUMS_SIZE;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    sched_state_e      state_q;
    logic [DESC_W-1:0] cfg_q, push_data, head;
    logic [WDOG_W-1:0] wdog_q;
    logic [GAP_W-1:0]  gap_q;
    logic [7:0]        cnt_q;
    logic [1:0]        wd_q;
    logic              start_q, done_q, bank_q, err_q;
    logic              full, empty, push, pop, flush, w_rise, wdog_hit;

    assign push_data = {bus.desc_tensor_size, bus.desc_kernel_size, bus.desc_channels,
                        bus.desc_stride, bus.desc_kernel_nums};
    assign bus.desc_ready = !full && !err_q;
    assign push     = bus.desc_valid && bus.desc_ready;
    assign pop      = (state_q == S_LOAD);
    assign w_rise   = wd_q[0] && !wd_q[1];
    assign wdog_hit = (wdog_q == '1);
    // Flush on the edge that enters ERR as well, so the queue reads empty throughout ERR.
    assign flush    = err_q || (state_q == S_RUN && !w_rise && wdog_hit);

    layer_desc_fifo #(.WIDTH(DESC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (push_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            wdog_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            bank_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Edge detector runs in every state so a level held over a layer boundary is not a new edge.
            wd_q    <= {wd_q[0], bus.acc_w_done};
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (run && !empty) state_q <= S_LOAD;
                S_LOAD: begin
                    cfg_q   <= head;
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    wdog_q  <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (w_rise) begin
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + 8'd1;
                        bank_q  <= !bank_q;
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end else if (wdog_hit) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        wdog_q  <= wdog_q + WDOG_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_q <= S_IDLE;
                    else                                 gap_q   <= gap_q + GAP_W'(1);
                end
                S_ERR: begin
                    if (err_clr) begin
                        err_q   <= 1'b0;
                        bank_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign {bus.cfg_tensor_size, bus.cfg_kernel_size, bus.cfg_channels,
            bus.cfg_stride, bus.cfg_kernel_nums} = cfg_q;
    assign bus.acc_start = start_q;
    assign res_bank      = bank_q;
    assign busy          = (state_q != S_IDLE);
    assign layer_done    = done_q;
    assign layers_done   = cnt_q;
    assign err           = err_q;
endmodule
